// File: rtl/xbus_pkg.sv
// Shared definitions for the XBus point-to-point link: word width, state
// encoding and the default stall threshold.
package xbus_pkg;

  localparam int XBUS_WIDTH       = 11;
  localparam int XBUS_STALL_TICKS = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HELD_A = 3'd1,
    HELD_B = 3'd2,
    ACK_A  = 3'd3,
    ACK_B  = 3'd4
  } xbus_state_t;

  function automatic logic is_held(input xbus_state_t s);
    return (s == HELD_A) || (s == HELD_B);
  endfunction

endpackage

// File: rtl/xbus_link_if.sv
// One MC9999 XBus port (x0 or x1) as seen between the core and the link.
interface xbus_link_if import xbus_pkg::*; #(
  parameter int WIDTH = XBUS_WIDTH
);

  // Handshake: write_req holds data_in stable until write_ack pulses for one
  // cycle; data_valid qualifies data_out, and a read_req sampled while
  // data_valid is high consumes that word on the same clock edge.
  logic [WIDTH-1:0] data_in;
  logic             write_req;
  logic             read_req;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             write_ack;

  modport master (
    output data_in, write_req, read_req,
    input  data_out, data_valid, write_ack
  );

  modport slave (
    input  data_in, write_req, read_req,
    output data_out, data_valid, write_ack
  );

endinterface

// File: rtl/xbus_stall_timer.sv
// Saturating counter of big-clock ticks with synchronous clear and a
// terminal flag; shared by the link stall monitor and the sleep path.
module xbus_stall_timer import xbus_pkg::*; #(
  parameter int MAX_TICKS = XBUS_STALL_TICKS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic tick,
  output logic terminal
);

  localparam logic [7:0] MAX_C = 8'(MAX_TICKS);

  logic [7:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 8'd0;
    end else if (clear) begin
      count <= 8'd0;
    end else if (tick && (count != MAX_C)) begin
      count <= count + 8'd1;
    end
  end

  assign terminal = (count == MAX_C);

endmodule

// File: rtl/xbus_link.sv
// Blocking-rendezvous XBus channel between two MC9999 cores (port A, port B).
// Optional transfer counters are enabled with XBUS_LINK_STATS_EN.
module xbus_link import xbus_pkg::*; #(
  parameter int WIDTH       = XBUS_WIDTH,
  parameter int STALL_TICKS = XBUS_STALL_TICKS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        posedge_big_clk,
  xbus_link_if.slave  port_a,
  xbus_link_if.slave  port_b,
  output logic        busy,
  output logic        stall,
  output xbus_state_t state
`ifdef XBUS_LINK_STATS_EN
  , output logic [15:0] xfer_count_a2b
  , output logic [15:0] xfer_count_b2a
`endif
);

  xbus_state_t      next_state;
  logic [WIDTH-1:0] buffer;
  logic             rr_last;
  logic             grant_a;
  logic             grant_b;
  logic             tie;
  logic             held;
  logic             timer_clear;
  logic             timer_tick;

  // rr_last records only the winner of simultaneous requests, so a lone
  // write never shifts the tie-break order.
  always_comb begin
    next_state = state;
    grant_a    = 1'b0;
    grant_b    = 1'b0;
    tie        = 1'b0;
    case (state)
      IDLE: begin
        tie = port_a.write_req && port_b.write_req;
        if (tie) begin
          grant_a = rr_last;
          grant_b = !rr_last;
        end else begin
          grant_a = port_a.write_req;
          grant_b = port_b.write_req;
        end
        if (grant_a)      next_state = HELD_A;
        else if (grant_b) next_state = HELD_B;
      end
      HELD_A:  if (port_b.read_req) next_state = ACK_A;
      HELD_B:  if (port_a.read_req) next_state = ACK_B;
      ACK_A:   next_state = IDLE;
      ACK_B:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      buffer            <= '0;
      rr_last           <= 1'b0;
      port_a.data_valid <= 1'b0;
      port_b.data_valid <= 1'b0;
      port_a.write_ack  <= 1'b0;
      port_b.write_ack  <= 1'b0;
      busy              <= 1'b0;
    end else begin
      state <= next_state;
      if (grant_a) buffer <= port_a.data_in;
      if (grant_b) buffer <= port_b.data_in;
      if (tie)     rr_last <= grant_b;
      port_b.data_valid <= (next_state == HELD_A);
      port_a.data_valid <= (next_state == HELD_B);
      port_a.write_ack  <= (next_state == ACK_A);
      port_b.write_ack  <= (next_state == ACK_B);
      busy              <= is_held(next_state);
    end
  end

  // Both ports see the buffer; data_valid decides who may use it.
  assign port_a.data_out = buffer;
  assign port_b.data_out = buffer;

  assign held        = is_held(state);
  assign timer_tick  = held && posedge_big_clk;
  assign timer_clear = !held || (next_state == ACK_A) || (next_state == ACK_B);

  xbus_stall_timer #(
    .MAX_TICKS (STALL_TICKS)
  ) u_stall_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (timer_clear),
    .tick     (timer_tick),
    .terminal (stall)
  );

`ifdef XBUS_LINK_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_count_a2b <= 16'd0;
      xfer_count_b2a <= 16'd0;
    end else begin
      if (state == HELD_A && next_state == ACK_A) xfer_count_a2b <= xfer_count_a2b + 16'd1;
      if (state == HELD_B && next_state == ACK_B) xfer_count_b2a <= xfer_count_b2a + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_xbus_link.sv
// Directed and randomized bench for xbus_link with an expected-word queue.
// Define XBUS_LINK_STATS_EN to also check the transfer counters.
module tb_xbus_link;
  import xbus_pkg::*;

  localparam int W = 11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        posedge_big_clk = 1'b0;
  logic        busy;
  logic        stall;
  xbus_state_t state;
`ifdef XBUS_LINK_STATS_EN
  logic [15:0] xfer_count_a2b;
  logic [15:0] xfer_count_b2a;
`endif

  xbus_link_if #(.WIDTH(W)) a_if ();
  xbus_link_if #(.WIDTH(W)) b_if ();

  xbus_link #(.WIDTH(W), .STALL_TICKS(3)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .posedge_big_clk (posedge_big_clk),
    .port_a          (a_if),
    .port_b          (b_if),
    .busy            (busy),
    .stall           (stall),
    .state           (state)
`ifdef XBUS_LINK_STATS_EN
    , .xfer_count_a2b (xfer_count_a2b)
    , .xfer_count_b2a (xfer_count_b2a)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];
  int           exp_a2b = 0;
  int           exp_b2a = 0;
  bit           tie_to_b = 1'b1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_write(input bit from_a, input bit req, input logic [W-1:0] d);
    if (from_a) begin a_if.write_req = req; a_if.data_in = d; end
    else        begin b_if.write_req = req; b_if.data_in = d; end
  endtask

  task automatic set_read(input bit on_a, input bit req);
    if (on_a) a_if.read_req = req;
    else      b_if.read_req = req;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_a_valid"}, a_if.data_valid, 0);
    check({tag, "_b_valid"}, b_if.data_valid, 0);
    check({tag, "_a_ack"},   a_if.write_ack, 0);
    check({tag, "_b_ack"},   b_if.write_ack, 0);
    check({tag, "_a_data"},  a_if.data_out, 0);
    check({tag, "_b_data"},  b_if.data_out, 0);
    check({tag, "_busy"},    busy, 0);
    check({tag, "_stall"},   stall, 0);
  endtask

  // Called just after the edge that latched the writer's word. Verifies the
  // word is presented to the peer only, lets it wait, then the peer reads it.
  task automatic xfer_held(input bit from_a, input int wait_cycles, input bit drop_write);
    logic [W-1:0] exp_word;
    exp_word = exp_q.pop_front();
    for (int i = 0; i <= wait_cycles; i++) begin
      check("held_reader_valid", from_a ? b_if.data_valid : a_if.data_valid, 1);
      check("held_reader_data",  from_a ? b_if.data_out : a_if.data_out, 32'(exp_word));
      check("held_writer_valid", from_a ? a_if.data_valid : b_if.data_valid, 0);
      check("held_busy", busy, 1);
      if (i < wait_cycles) tick();
    end
    set_read(!from_a, 1'b1);
    tick();
    check("ack_writer",  from_a ? a_if.write_ack : b_if.write_ack, 1);
    check("ack_other",   from_a ? b_if.write_ack : a_if.write_ack, 0);
    check("ack_reader_valid", from_a ? b_if.data_valid : a_if.data_valid, 0);
    check("ack_busy", busy, 0);
    if (from_a) exp_a2b++; else exp_b2a++;
    set_read(!from_a, 1'b0);
    if (drop_write) set_write(from_a, 1'b0, '0);
    tick();
    check("after_ack_writer", from_a ? a_if.write_ack : b_if.write_ack, 0);
    check("after_ack_idle", 32'(state), 32'(IDLE));
  endtask

  initial begin
    logic [W-1:0] d0;
    logic [W-1:0] d1;
    int           mode;
    bit           win_a;
    bit           saw_b_ack;

    a_if.data_in = '0; a_if.write_req = 1'b0; a_if.read_req = 1'b0;
    b_if.data_in = '0; b_if.write_req = 1'b0; b_if.read_req = 1'b0;

    // Reset state
    repeat (3) tick();
    check_outputs_zero("reset");
    check("reset_state", 32'(state), 32'(IDLE));
    rst_n = 1'b1;
    tick();

    // Simple A->B with 321, read three cycles after the latch
    set_write(1'b1, 1'b1, 11'd321);
    exp_q.push_back(11'd321);
    tick();
    xfer_held(1'b1, 2, 1'b1);

    // Simultaneous writes after reset: B wins, then A alone, then A wins tie
    set_write(1'b1, 1'b1, 11'd5);
    set_write(1'b0, 1'b1, 11'd7);
    tick();
    check("tie1_a_data", a_if.data_out, 7);
    check("tie1_b_valid", b_if.data_valid, 0);
    tie_to_b = 1'b0;
    exp_q.push_back(11'd7);
    xfer_held(1'b0, 0, 1'b1);
    tick();
    exp_q.push_back(11'd5);
    xfer_held(1'b1, 1, 1'b1);
    set_write(1'b1, 1'b1, 11'd9);
    set_write(1'b0, 1'b1, 11'd12);
    tick();
    check("tie2_b_data", b_if.data_out, 9);
    check("tie2_a_valid", a_if.data_valid, 0);
    tie_to_b = 1'b1;
    exp_q.push_back(11'd9);
    xfer_held(1'b1, 0, 1'b1);
    tick();
    exp_q.push_back(11'd12);
    xfer_held(1'b0, 0, 1'b1);

    // Self-read blocked: A holds its own read request for 20 cycles
    set_write(1'b1, 1'b1, 11'd100);
    set_read(1'b1, 1'b1);
    tick();
    for (int i = 0; i < 20; i++) begin
      check("self_a_valid", a_if.data_valid, 0);
      check("self_a_ack", a_if.write_ack, 0);
      check("self_busy", busy, 1);
      tick();
    end
    set_read(1'b1, 1'b0);
    exp_q.push_back(11'd100);
    xfer_held(1'b1, 0, 1'b1);

    // Stall after three big-clock pulses, cleared in the ack cycle
    set_write(1'b1, 1'b1, 11'd55);
    tick();
    for (int p = 1; p <= 4; p++) begin
      repeat (9) tick();
      check("stall_before_pulse", stall, (p > 3) ? 1 : 0);
      posedge_big_clk = 1'b1;
      tick();
      posedge_big_clk = 1'b0;
      check("stall_after_pulse", stall, (p >= 3) ? 1 : 0);
    end
    set_read(1'b0, 1'b1);
    posedge_big_clk = 1'b1;
    tick();
    posedge_big_clk = 1'b0;
    check("stall_ack_cycle", stall, 0);
    check("stall_ack", a_if.write_ack, 1);
    check("stall_data", b_if.data_out, 55);
    exp_a2b++;
    set_read(1'b0, 1'b0);
    set_write(1'b1, 1'b0, '0);
    tick();
    check("stall_after", stall, 0);

    // Reset while HELD_B: word lost, no ack, next write accepted
    set_write(1'b0, 1'b1, 11'd77);
    tick();
    check("rst_pre_valid", a_if.data_valid, 1);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("rst_mid");
    set_write(1'b0, 1'b0, '0);
    saw_b_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      saw_b_ack |= b_if.write_ack;
      check("rst_hold_busy", busy, 0);
    end
    rst_n = 1'b1;
    exp_a2b = 0; exp_b2a = 0; tie_to_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      saw_b_ack |= b_if.write_ack;
    end
    check("rst_no_b_ack", saw_b_ack, 0);
    check("rst_state", 32'(state), 32'(IDLE));
    set_write(1'b1, 1'b1, 11'd200);
    exp_q.push_back(11'd200);
    tick();
    xfer_held(1'b1, 1, 1'b1);

    // Randomized transfers: single writers and ties
    for (int t = 0; t < 40; t++) begin
      d0   = W'($urandom_range(0, 2047));
      d1   = W'($urandom_range(0, 2047));
      mode = $urandom_range(0, 2);
      if (mode == 2) begin
        win_a = !tie_to_b;
        tie_to_b = !tie_to_b;
        set_write(1'b1, 1'b1, d0);
        set_write(1'b0, 1'b1, d1);
        exp_q.push_back(win_a ? d0 : d1);
        exp_q.push_back(win_a ? d1 : d0);
        tick();
        xfer_held(win_a, $urandom_range(0, 3), 1'b1);
        tick();
        xfer_held(!win_a, $urandom_range(0, 3), 1'b1);
      end else begin
        set_write(mode == 0, 1'b1, d0);
        exp_q.push_back(d0);
        tick();
        xfer_held(mode == 0, $urandom_range(0, 3), 1'b1);
      end
      repeat ($urandom_range(0, 2)) tick();
    end
    check("queue_drained", exp_q.size(), 0);

`ifdef XBUS_LINK_STATS_EN
    check("stats_a2b", xfer_count_a2b, exp_a2b);
    check("stats_b2a", xfer_count_b2a, exp_b2a);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
